cache_arbiter: RTL and testbench

CACHE_ARBITER -- requirements
Module: cache_arbiter

---
 rtl/cache_arbiter.sv | 126 ++++++++++++
 tb/tb_cache_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// Two-port cacheline fill/writeback arbiter: shares one memory port between
// the instruction and data caches, one transaction at a time.
//
//   state   | meaning
//   IDLE    | no transaction; requests sampled for the next grant
//   GRANT_I | instruction fill in flight on the memory port
//   GRANT_D | data fill or writeback in flight on the memory port
//   RESP    | completion pulse cycle to the served cache
module cache_arbiter #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RESP} state_t;

  state_t                state, state_nxt;
  logic                  owed, owed_nxt;
  logic                  pmem_read_nxt, pmem_write_nxt;
  logic                  i_resp_nxt, d_resp_nxt;
  logic [ADDR_WIDTH-1:0] pmem_address_nxt;
  logic [LINE_WIDTH-1:0] pmem_wdata_nxt, i_rdata_nxt, d_rdata_nxt;
  logic                  d_req;
  logic [ADDR_WIDTH-1:0] i_line_addr, d_line_addr;

  assign d_req       = d_read | d_write;
  assign i_line_addr = {i_address[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  assign d_line_addr = {d_address[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      owed         <= 1'b0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      i_rdata      <= '0;
      d_rdata      <= '0;
      i_resp       <= 1'b0;
      d_resp       <= 1'b0;
    end else begin
      state        <= state_nxt;
      owed         <= owed_nxt;
      pmem_read    <= pmem_read_nxt;
      pmem_write   <= pmem_write_nxt;
      pmem_address <= pmem_address_nxt;
      pmem_wdata   <= pmem_wdata_nxt;
      i_rdata      <= i_rdata_nxt;
      d_rdata      <= d_rdata_nxt;
      i_resp       <= i_resp_nxt;
      d_resp       <= d_resp_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    owed_nxt         = owed;
    pmem_read_nxt    = pmem_read;
    pmem_write_nxt   = pmem_write;
    pmem_address_nxt = pmem_address;
    pmem_wdata_nxt   = pmem_wdata;
    i_rdata_nxt      = i_rdata;
    d_rdata_nxt      = d_rdata;
    i_resp_nxt       = 1'b0;
    d_resp_nxt       = 1'b0;
    case (state)
      IDLE: begin
        // D normally wins, but an I fill that was passed over gets the next turn
        if (d_req && !(owed && i_read)) begin
          state_nxt        = GRANT_D;
          pmem_write_nxt   = d_write;
          pmem_read_nxt    = ~d_write;
          pmem_address_nxt = d_line_addr;
          pmem_wdata_nxt   = d_wdata;
          owed_nxt         = owed | i_read;
        end else if (i_read) begin
          state_nxt        = GRANT_I;
          pmem_read_nxt    = 1'b1;
          pmem_address_nxt = i_line_addr;
          owed_nxt         = 1'b0;
        end
      end
      GRANT_I: begin
        if (pmem_resp) begin
          state_nxt     = RESP;
          pmem_read_nxt = 1'b0;
          i_rdata_nxt   = pmem_rdata;
          i_resp_nxt    = 1'b1;
        end
      end
      GRANT_D: begin
        if (pmem_resp) begin
          state_nxt      = RESP;
          pmem_read_nxt  = 1'b0;
          pmem_write_nxt = 1'b0;
          if (!pmem_write) d_rdata_nxt = pmem_rdata;
          d_resp_nxt     = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed vector table, reset sequences, and a
// randomized run checked against a transaction-level reference model.
module tb_cache_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk, rst;
  logic          i_read;
  logic [AW-1:0] i_address;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read, d_write;
  logic [AW-1:0] d_address;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read, pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  int n_vec = 0;
  int n_err = 0;

  cache_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checka(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkl(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] line_of(input logic [AW-1:0] a);
    return a & 32'hFFFF_FFE0;
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int k = 0; k < LW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  typedef struct {
    logic          ir;
    logic [AW-1:0] ia;
    logic          dr;
    logic          dw;
    logic [AW-1:0] da;
    logic [7:0]    wb;
    logic          ps;
    logic [7:0]    rb;
    logic          epr;
    logic          epw;
    logic [AW-1:0] ea;
    logic [7:0]    ewb;
    logic          eir;
    logic          edr;
    logic [7:0]    eirb;
    logic [7:0]    edrb;
  } vec_t;

  vec_t tbl[24];

  // Reference model state for the randomized run
  logic          p_ir, p_dr, p_dw, p_ps;
  logic [AW-1:0] p_ia, p_da;
  logic [LW-1:0] p_dwd, p_prd;
  bit            m_busy, m_owner_d, m_wr, m_owed;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata, m_irdata, m_drdata;
  int            e, m_resp_edge, m_free_edge;

  task automatic clear_inputs();
    i_read = 1'b0; i_address = '0;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
    pmem_resp = 1'b0; pmem_rdata = '0;
  endtask

  initial begin
    //            ir    ia             dr    dw    da             wb     ps    rb     epr   epw   ea             ewb    eir   edr   eirb   edrb
    tbl[0]  = '{1'b1, 32'h0000_1234, 1'b0, 1'b0, 32'h0,         8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0000_1220, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[1]  = '{1'b1, 32'h0000_1234, 1'b0, 1'b0, 32'h0,         8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0000_1220, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[2]  = '{1'b1, 32'h0000_1234, 1'b0, 1'b0, 32'h0,         8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0000_1220, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[3]  = '{1'b1, 32'h0000_1234, 1'b0, 1'b0, 32'h0,         8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0000_1220, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[4]  = '{1'b1, 32'h0000_1234, 1'b0, 1'b0, 32'h0,         8'h00, 1'b1, 8'hA5, 1'b0, 1'b0, 32'h0,         8'h00, 1'b1, 1'b0, 8'hA5, 8'h00};
    tbl[5]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0,         8'h00, 1'b0, 1'b0, 8'hA5, 8'h00};
    tbl[6]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 32'h0,         8'h00, 1'b0, 1'b0, 8'hA5, 8'h00};
    tbl[7]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0,         8'h00, 1'b0, 1'b0, 8'hA5, 8'h00};
    tbl[8]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h8000_0040, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b1, 32'h8000_0040, 8'h5A, 1'b0, 1'b0, 8'hA5, 8'h00};
    tbl[9]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h1111_1111, 8'h33, 1'b0, 8'h00, 1'b0, 1'b1, 32'h8000_0040, 8'h5A, 1'b0, 1'b0, 8'hA5, 8'h00};
    tbl[10] = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h1111_1111, 8'h33, 1'b1, 8'hC3, 1'b0, 1'b0, 32'h0,         8'h00, 1'b0, 1'b1, 8'hA5, 8'h00};
    tbl[11] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0,         8'h00, 1'b0, 1'b0, 8'hA5, 8'h00};
    tbl[12] = '{1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'h0000_0200, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0000_0200, 8'h00, 1'b0, 1'b0, 8'hA5, 8'h00};
    tbl[13] = '{1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'h0000_0200, 8'h00, 1'b1, 8'h77, 1'b0, 1'b0, 32'h0,         8'h00, 1'b0, 1'b1, 8'hA5, 8'h77};
    tbl[14] = '{1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0,         8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0,         8'h00, 1'b0, 1'b0, 8'hA5, 8'h77};
    tbl[15] = '{1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'h0000_0300, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0000_0100, 8'h00, 1'b0, 1'b0, 8'hA5, 8'h77};
    tbl[16] = '{1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'h0000_0300, 8'h00, 1'b1, 8'h88, 1'b0, 1'b0, 32'h0,         8'h00, 1'b1, 1'b0, 8'h88, 8'h77};
    tbl[17] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0300, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0,         8'h00, 1'b0, 1'b0, 8'h88, 8'h77};
    tbl[18] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0300, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0000_0300, 8'h00, 1'b0, 1'b0, 8'h88, 8'h77};
    tbl[19] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0300, 8'h00, 1'b1, 8'h99, 1'b0, 1'b0, 32'h0,         8'h00, 1'b0, 1'b1, 8'h88, 8'h99};
    tbl[20] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0,         8'h00, 1'b0, 1'b0, 8'h88, 8'h99};
    tbl[21] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0440, 8'h12, 1'b0, 8'h00, 1'b0, 1'b1, 32'h0000_0440, 8'h12, 1'b0, 1'b0, 8'h88, 8'h99};
    tbl[22] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0440, 8'h12, 1'b1, 8'hEE, 1'b0, 1'b0, 32'h0,         8'h00, 1'b0, 1'b1, 8'h88, 8'h99};
    tbl[23] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0,         8'h00, 1'b0, 1'b0, 8'h88, 8'h99};

    rst = 1'b0;
    clear_inputs();
    #12;
    check1("rst_pmem_read", pmem_read, 1'b0);
    check1("rst_pmem_write", pmem_write, 1'b0);
    checka("rst_pmem_address", pmem_address, '0);
    checkl("rst_pmem_wdata", pmem_wdata, '0);
    checkl("rst_i_rdata", i_rdata, '0);
    checkl("rst_d_rdata", d_rdata, '0);
    check1("rst_i_resp", i_resp, 1'b0);
    check1("rst_d_resp", d_resp, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < 24; k++) begin
      i_read     = tbl[k].ir;
      i_address  = tbl[k].ia;
      d_read     = tbl[k].dr;
      d_write    = tbl[k].dw;
      d_address  = tbl[k].da;
      d_wdata    = {32{tbl[k].wb}};
      pmem_resp  = tbl[k].ps;
      pmem_rdata = {32{tbl[k].rb}};
      @(posedge clk);
      #1;
      check1($sformatf("tbl%0d_pmem_read", k), pmem_read, tbl[k].epr);
      check1($sformatf("tbl%0d_pmem_write", k), pmem_write, tbl[k].epw);
      check1($sformatf("tbl%0d_i_resp", k), i_resp, tbl[k].eir);
      check1($sformatf("tbl%0d_d_resp", k), d_resp, tbl[k].edr);
      checkl($sformatf("tbl%0d_i_rdata", k), i_rdata, {32{tbl[k].eirb}});
      checkl($sformatf("tbl%0d_d_rdata", k), d_rdata, {32{tbl[k].edrb}});
      if (tbl[k].epr || tbl[k].epw)
        checka($sformatf("tbl%0d_pmem_address", k), pmem_address, tbl[k].ea);
      if (tbl[k].epw)
        checkl($sformatf("tbl%0d_pmem_wdata", k), pmem_wdata, {32{tbl[k].ewb}});
    end

    // Reset asserted in the middle of an instruction fill
    i_read = 1'b1;
    i_address = 32'h0000_2000;
    @(posedge clk);
    #1;
    check1("midrst_grant", pmem_read, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check1("midrst_pmem_read", pmem_read, 1'b0);
    checka("midrst_pmem_address", pmem_address, '0);
    check1("midrst_i_resp", i_resp, 1'b0);
    checkl("midrst_i_rdata", i_rdata, '0);
    checkl("midrst_d_rdata", d_rdata, '0);
    i_read = 1'b0;
    pmem_resp = 1'b1;
    pmem_rdata = {32{8'hFF}};
    @(posedge clk);
    #1;
    check1("inrst_i_resp", i_resp, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check1("postrst_i_resp", i_resp, 1'b0);
    check1("postrst_pmem_read", pmem_read, 1'b0);
    checkl("postrst_i_rdata", i_rdata, '0);
    pmem_resp = 1'b0;

    // Request held through reset release is granted on the first edge with rst high
    rst = 1'b0;
    i_read = 1'b1;
    i_address = 32'h0000_3018;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check1("release_no_early_grant", pmem_read, 1'b0);
    @(posedge clk);
    #1;
    check1("release_grant", pmem_read, 1'b1);
    checka("release_addr", pmem_address, 32'h0000_3000);
    pmem_resp = 1'b1;
    pmem_rdata = {32{8'h42}};
    @(posedge clk);
    #1;
    check1("release_i_resp", i_resp, 1'b1);
    checkl("release_i_rdata", i_rdata, {32{8'h42}});
    check1("release_cmd_drop", pmem_read, 1'b0);
    i_read = 1'b0;
    pmem_resp = 1'b0;
    @(posedge clk);
    #1;
    check1("release_resp_single", i_resp, 1'b0);

    // Randomized run against the transaction-level model
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
    m_busy = 1'b0; m_owner_d = 1'b0; m_wr = 1'b0; m_owed = 1'b0;
    m_addr = '0; m_wdata = '0; m_irdata = '0; m_drdata = '0;
    e = 0; m_resp_edge = -1; m_free_edge = 0;

    for (int k = 0; k < 3000; k++) begin
      int op;
      p_ir = i_read; p_ia = i_address;
      p_dr = d_read; p_dw = d_write; p_da = d_address; p_dwd = d_wdata;
      p_ps = pmem_resp; p_prd = pmem_rdata;
      @(posedge clk);
      #1;
      e++;

      if (!m_busy) begin
        if (e >= m_free_edge) begin
          if ((p_dr || p_dw) && !(m_owed && p_ir)) begin
            m_busy = 1'b1; m_owner_d = 1'b1; m_wr = p_dw;
            m_addr = line_of(p_da); m_wdata = p_dwd;
            if (p_ir) m_owed = 1'b1;
          end else if (p_ir) begin
            m_busy = 1'b1; m_owner_d = 1'b0; m_wr = 1'b0;
            m_addr = line_of(p_ia); m_owed = 1'b0;
          end
        end
      end else if (p_ps) begin
        m_busy = 1'b0;
        m_resp_edge = e;
        m_free_edge = e + 2;
        if (m_owner_d && !m_wr) m_drdata = p_prd;
        if (!m_owner_d) m_irdata = p_prd;
      end

      check1("rnd_pmem_read", pmem_read, m_busy && !m_wr);
      check1("rnd_pmem_write", pmem_write, m_busy && m_wr);
      check1("rnd_i_resp", i_resp, (e == m_resp_edge) && !m_owner_d);
      check1("rnd_d_resp", d_resp, (e == m_resp_edge) && m_owner_d);
      checkl("rnd_i_rdata", i_rdata, m_irdata);
      checkl("rnd_d_rdata", d_rdata, m_drdata);
      if (m_busy) checka("rnd_pmem_address", pmem_address, m_addr);
      if (m_busy && m_wr) checkl("rnd_pmem_wdata", pmem_wdata, m_wdata);

      if (i_read) begin
        if (i_resp) i_read = 1'b0;
        else i_address = $urandom;
      end else if ($urandom_range(0, 2) == 0) begin
        i_read = 1'b1;
        i_address = $urandom;
      end

      if (d_read || d_write) begin
        if (d_resp) begin
          d_read = 1'b0;
          d_write = 1'b0;
        end else begin
          d_address = $urandom;
          d_wdata = rand_line();
        end
      end else if ($urandom_range(0, 2) == 0) begin
        op = $urandom_range(0, 2);
        d_read = (op != 1);
        d_write = (op != 0);
        d_address = $urandom;
        d_wdata = rand_line();
      end

      pmem_resp = ($urandom_range(0, 3) == 0);
      pmem_rdata = rand_line();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
